// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers for rr_arb_mux and its arbiter core.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int ARB_MAX_N = 16;
  localparam int ARB_IDXW  = $clog2(ARB_MAX_N);

  // Index of the set bit in a one-hot vector taken from the rotated
  // (pointer-relative) request space; an all-zero input yields 0.
  function automatic logic [ARB_IDXW-1:0] rot_oh_to_idx(input logic [ARB_MAX_N-1:0] oh);
    logic [ARB_IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | ARB_IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational arbiter: rotate-priority round-robin from ptr, or single fixed channel.
// Latency: 0 cycles (pure combinational).
// Backpressure: none here; the caller gates the grant with its load condition.
module rr_arb_core
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [SELW-1:0]     ptr,
  input  arb_pkg::arb_mode_e  mode,
  input  logic [SELW-1:0]     sel_fixed,
  output logic [N-1:0]        gnt_oh,
  output logic [SELW-1:0]     gnt_idx,
  output logic                any_grant
);
  import arb_pkg::*;

  logic [N-1:0]          elig;
  logic [N-1:0]          rot;
  logic [N-1:0]          rot_oh;
  logic [ARB_IDXW-1:0]   rot_idx;
  int                    src;
  int                    sum;

  // Eligible set: every requester in round-robin, only an in-range sel_fixed otherwise.
  always_comb begin
    elig = '0;
    if (mode == ARB_RR) begin
      elig = req;
    end else if (int'(sel_fixed) < N) begin
      elig[sel_fixed] = req[sel_fixed];
    end
  end

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    src = 0;
    sum = 0;
    rot = '0;
    for (int k = 0; k < N; k++) begin
      src = int'(ptr) + k;
      if (src >= N) src = src - N;
      rot[k] = elig[src];
    end
    rot_oh    = rot & (~rot + N'(1));
    rot_idx   = rot_oh_to_idx(ARB_MAX_N'(rot_oh));
    any_grant = |elig;
    sum       = int'(ptr) + int'(rot_idx);
    if (sum >= N) sum = sum - N;
    gnt_idx   = any_grant ? SELW'(sum) : '0;
    gnt_oh    = any_grant ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-way valid/ready stream mux with round-robin or fixed-select arbitration into a one-entry output register.
// Latency: 1 cycle from input transfer to out_valid; sustains one beat per cycle when out_ready stays high.
// Backpressure: in_ready is all-zero while the held beat is not draining; optional stats under RR_ARB_MUX_STATS_EN.
module rr_arb_mux
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel_fixed,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      grant_id
`ifdef RR_ARB_MUX_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  input  logic                 grant_cnt_clr
`endif
);
  import arb_pkg::*;

  logic [SELW-1:0] ptr;
  logic [N-1:0]    gnt_oh;
  logic [SELW-1:0] gnt_idx;
  logic            any_grant;
  logic            load;
  logic            xfer;
  arb_mode_e       arb_mode;

  assign arb_mode = arb_mode_e'(mode);

  rr_arb_core #(
    .N    (N),
    .SELW (SELW)
  ) u_core (
    .req       (in_valid),
    .ptr       (ptr),
    .mode      (arb_mode),
    .sel_fixed (sel_fixed),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .any_grant (any_grant)
  );

  // The register can take a beat when empty or draining; the winner is already
  // known to be valid, so a grant here is a completed transfer.
  assign load     = !out_valid || out_ready;
  assign xfer     = !rst && load && any_grant;
  assign in_ready = xfer ? gnt_oh : '0;

  // Output register, pointer advance on round-robin grants, drain when nothing new arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_id  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      grant_id  <= gnt_idx;
      if (arb_mode == ARB_RR) begin
        ptr <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_ARB_MUX_STATS_EN
  // Saturating count of cycles the consumer stalls a held beat; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || grant_cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: scoreboarded beats from a reference arbitration model.
// Latency: checks in_ready before each edge and the registered beat 1 time unit after it.
// Backpressure: exercises stalls, drains, fixed select, wrap, reset and the optional stats counter.
module tb_rr_arb_mux;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = $clog2(N);

  typedef struct packed {
    logic [SW-1:0] id;
    logic [W-1:0]  data;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel_fixed;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  grant_id;

  // Three-channel instance: the only way to present a sel_fixed value >= N.
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic           mode3;
  logic [1:0]     sel3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic           out_ready3;
  logic [1:0]     grant_id3;

`ifdef RR_ARB_MUX_STATS_EN
  logic [31:0]    stall_cnt;
  logic [31:0]    stall_cnt3;
  logic           clr;
  logic [31:0]    m_stall;
`endif

  int      checks = 0;
  int      errors = 0;
  beat_t   sbq[$];
  beat_t   cur;
  int      m_ptr;
  bit      m_ov;
  logic [1:0] sp_exp [4];

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(W), .N(N)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel_fixed (sel_fixed),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id)
`ifdef RR_ARB_MUX_STATS_EN
    ,
    .stall_cnt     (stall_cnt),
    .grant_cnt_clr (clr)
`endif
  );

  rr_arb_mux #(.WIDTH(W), .N(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (mode3),
    .sel_fixed (sel3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .grant_id  (grant_id3)
`ifdef RR_ARB_MUX_STATS_EN
    ,
    .stall_cnt     (stall_cnt3),
    .grant_cnt_clr (clr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the arbitration for the current inputs, check in_ready,
  // push the expected beat, then check the registered output after the edge.
  task automatic cycle(input string tag);
    logic         ld;
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    int           g;
    int           c;
    bit           found;
    bit           xfer;
    @(negedge clk);
    ld    = !m_ov || out_ready;
    elig  = (mode == 1'b0) ? in_valid : (in_valid & (N'(1) << sel_fixed));
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (!found && elig[c]) begin
        found = 1'b1;
        g     = c;
      end
    end
    xfer    = !rst && ld && found;
    exp_rdy = xfer ? (N'(1) << g) : '0;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    if (xfer) sbq.push_back('{id: SW'(g), data: in_data[g*W +: W]});
`ifdef RR_ARB_MUX_STATS_EN
    if (rst || clr) m_stall = 0;
    else if (m_ov && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      m_ov  = 1'b0;
      m_ptr = 0;
      cur   = '0;
      sbq.delete();
    end else if (xfer) begin
      cur  = sbq.pop_front();
      m_ov = 1'b1;
      if (mode == 1'b0) m_ptr = (g + 1) % N;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    chk({tag, ".out_data"},  64'(out_data),  64'(cur.data));
    chk({tag, ".grant_id"},  64'(grant_id),  64'(cur.id));
`ifdef RR_ARB_MUX_STATS_EN
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = '1;
    mode       = 1'b0;
    sel_fixed  = '0;
    out_ready  = 1'b1;
    in_valid3  = '0;
    mode3      = 1'b0;
    sel3       = '0;
    out_ready3 = 1'b1;
    m_ptr      = 0;
    m_ov       = 1'b0;
    cur        = '0;
    sp_exp     = '{2'd3, 2'd0, 2'd3, 2'd0};
`ifdef RR_ARB_MUX_STATS_EN
    clr        = 1'b0;
    m_stall    = 0;
`endif
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hC0DE_0000 + 32'(i);
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = 32'hBEEF_0000 + 32'(i);

    // Reset held with every channel requesting.
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;

    // Round-robin fairness: 8 beats in 8 cycles, 0,1,2,3 twice.
    for (int i = 0; i < 8; i++) begin
      cycle("rr");
      chk("rr_seq", 64'(grant_id), 64'(i % 4));
    end

    // Back-pressure with the channel-2 beat held.
    cycle("bp_pre");
    cycle("bp_pre");
    cycle("bp_pre");
    chk("bp_held_id", 64'(grant_id), 64'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle("bp_stall");
    out_ready = 1'b1;
    cycle("bp_release");
    chk("bp_next_id", 64'(grant_id), 64'd3);

    // Fixed select on channel 1; pointer must not move.
    mode      = 1'b1;
    sel_fixed = 2'd1;
    for (int i = 0; i < 4; i++) begin
      cycle("fix");
      chk("fix_id", 64'(grant_id), 64'd1);
    end
    mode = 1'b0;
    cycle("fix_ptr");
    chk("fix_ptr_id", 64'(grant_id), 64'd0);

    // Sparse requests on 3 and 0 with wrap-around.
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cycle("sparse");
      chk("sparse_id", 64'(grant_id), 64'(sp_exp[i]));
    end

    // Mid-stream reset drops the beat and clears the pointer.
    rst = 1'b1;
    cycle("mrst");
    chk("mrst_valid", 64'(out_valid), 64'd0);
    rst      = 1'b0;
    in_valid = '1;
    cycle("post_rst");
    chk("post_rst_id", 64'(grant_id), 64'd0);

    // Drain with no new requests; data and id hold.
    in_valid = '0;
    cycle("drain");
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Out-of-range fixed select on the three-channel instance.
    mode3     = 1'b1;
    sel3      = 2'd3;
    in_valid3 = 3'b111;
    @(negedge clk);
    chk("n3_oor_ready", 64'(in_ready3), 64'd0);
    @(posedge clk);
    #1;
    chk("n3_oor_valid", 64'(out_valid3), 64'd0);
    sel3 = 2'd2;
    @(negedge clk);
    chk("n3_sel2_ready", 64'(in_ready3), 64'b100);
    @(posedge clk);
    #1;
    chk("n3_sel2_valid", 64'(out_valid3), 64'd1);
    chk("n3_sel2_id",    64'(grant_id3),  64'd2);
    chk("n3_sel2_data",  64'(out_data3),  64'h0000_0000_BEEF_0002);
    sel3 = 2'd3;
    @(negedge clk);
    chk("n3_oor2_ready", 64'(in_ready3), 64'd0);
    @(posedge clk);
    #1;
    chk("n3_drained", 64'(out_valid3), 64'd0);
    in_valid3 = '0;

`ifdef RR_ARB_MUX_STATS_EN
    // Stall counter: clear during a stall, count 7 stalls, clear again.
    in_valid = 4'b0001;
    cycle("st_load");
    in_valid  = '0;
    out_ready = 1'b0;
    clr       = 1'b1;
    cycle("st_clr0");
    chk("stall_clr0", 64'(stall_cnt), 64'd0);
    clr = 1'b0;
    for (int i = 0; i < 7; i++) cycle("st_stall");
    chk("stall_seven", 64'(stall_cnt), 64'd7);
    clr = 1'b1;
    cycle("st_clr1");
    chk("stall_clr1", 64'(stall_cnt), 64'd0);
    clr       = 1'b0;
    out_ready = 1'b1;
    cycle("st_drain");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
